// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Read-side consumer for an asynchronous FIFO. It pulls bytes through the
//   FIFO read port and packs PACK_COUNT consecutive bytes into one wide word.
//   The word is offered on a valid/ready stream. A flush pulse pushes out
//   whatever is buffered as a partial word. Everything runs in the FIFO read
//   clock domain.
//
// Ports
//   clk         single clock, tied to the FIFO read clock
//   rst         synchronous, active-high reset
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO read data, registered: valid the cycle after fifo_en_rd
//   fifo_en_rd  FIFO read enable (combinational)
//   flush       single-cycle request to emit the buffered partial word
//   out_valid   output word valid
//   out_ready   downstream accept; a transfer happens on out_valid & out_ready
//   out_data    packed word; the first byte read sits in lane 0 (LSBs)
//   out_bytes   number of valid lanes, 1..PACK_COUNT
//   out_last    word was produced by a flush
//   flush_done  one-cycle pulse when a flush has fully completed
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_COUNT = 4,
  localparam int CNT_W     = $clog2(PACK_COUNT + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_dout,
  output logic                             fifo_en_rd,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*PACK_COUNT-1:0] out_data,
  output logic [CNT_W-1:0]                 out_bytes,
  output logic                             out_last,
  output logic                             flush_done
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_OUT  = 1'b1
  } state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic [CNT_W-1:0]                 r_count;
  logic                             r_pending;
  logic                             r_flush_req;
  logic [DATA_WIDTH*PACK_COUNT-1:0] r_lanes;
  logic [CNT_W-1:0]                 r_out_bytes;
  logic                             r_out_last;

  logic [CNT_W:0]                   w_inflight;
  logic                             w_en_rd;
  logic                             w_full_word;
  logic                             w_flush_word;
  logic                             w_accept;
  logic                             w_flush_done;

  // Bytes already captured plus the one still in flight from the FIFO; a new
  // read is only allowed while this leaves room in the word.
  assign w_inflight = {1'b0, r_count} + {{CNT_W{1'b0}}, r_pending};

  assign w_en_rd = !rst && (r_state == S_FILL) && !fifo_empty && !r_flush_req &&
                   (w_inflight < (CNT_W + 1)'(PACK_COUNT));

  always_comb begin
    w_state_nxt  = r_state;
    w_full_word  = 1'b0;
    w_flush_word = 1'b0;
    w_accept     = 1'b0;
    w_flush_done = 1'b0;
    case (r_state)
      S_FILL: begin
        if (r_pending && (r_count == CNT_W'(PACK_COUNT - 1))) begin
          // The byte landing this cycle completes the word.
          w_full_word = 1'b1;
          w_state_nxt = S_OUT;
        end else if (r_flush_req && !r_pending) begin
          // Flush only acts once the in-flight byte has been captured.
          if (r_count != '0) begin
            w_flush_word = 1'b1;
            w_state_nxt  = S_OUT;
          end else begin
            w_flush_done = 1'b1;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture / word assembly stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_pending   <= 1'b0;
      r_flush_req <= 1'b0;
      r_lanes     <= '0;
      r_out_bytes <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_pending <= w_en_rd;

      // A flush arriving while one is outstanding (or completing) is dropped.
      if (w_flush_done) begin
        r_flush_req <= 1'b0;
      end else if (flush) begin
        r_flush_req <= 1'b1;
      end

      // fifo_dout is only meaningful the cycle after a read; otherwise the
      // FIFO idles at all-ones and must be ignored.
      if (r_pending) begin
        for (int i = 0; i < PACK_COUNT; i++) begin
          if (r_count == CNT_W'(i)) begin
            r_lanes[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_dout;
          end
        end
        r_count <= r_count + CNT_W'(1);
      end

      if (w_full_word) begin
        r_out_bytes <= CNT_W'(PACK_COUNT);
        r_out_last  <= 1'b0;
      end

      if (w_flush_word) begin
        r_out_bytes <= r_count;
        r_out_last  <= 1'b1;
      end

      // Clearing the lanes on accept keeps unused lanes of a later partial
      // word at zero.
      if (w_accept) begin
        r_lanes     <= '0;
        r_count     <= '0;
        r_out_bytes <= '0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign fifo_en_rd = w_en_rd;
  assign out_valid  = (r_state == S_OUT);
  assign out_data   = r_lanes;
  assign out_bytes  = r_out_bytes;
  assign out_last   = r_out_last;
  assign flush_done = w_flush_done && !rst;

endmodule

// File: tb/tb_fifo_rd_packer.sv
module tb_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty;
  logic [7:0]  fifo_dout = 8'hFF;
  logic        fifo_en_rd;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_last;
  logic        flush_done;

  always #5 clk = ~clk;

  fifo_rd_packer #(.DATA_WIDTH(8), .PACK_COUNT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_en_rd (fifo_en_rd),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_bytes  (out_bytes),
    .out_last   (out_last),
    .flush_done (flush_done)
  );

  // FIFO read-port model: registered Dout, all-ones when not reading.
  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       empty_gate = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr) || empty_gate;

  always @(posedge clk) begin
    if (fifo_en_rd) begin
      fifo_dout <= mem[6'(rd_ptr)];
      rd_ptr    <= rd_ptr + 1;
    end else begin
      fifo_dout <= 8'hFF;
    end
  end

  // Output monitor: records every accepted word.
  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  b;
    logic        l;
  } word_t;

  word_t got [0:63];
  int    got_wr = 0;
  int    got_rd = 0;
  word_t exp_q [$];

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got[6'(got_wr)] <= {out_data, out_bytes, out_last};
      got_wr          <= got_wr + 1;
    end
  end

  typedef struct {
    int          n;
    logic [31:0] din;
    logic        fl;
    logic [31:0] ed;
    logic [2:0]  eb;
    logic        el;
  } vec_t;

  vec_t       vecs [6];
  int         errors = 0;
  int         checks = 0;
  int         bad, base, fd_n, fd_at, acc_at, n;
  logic [7:0] en_pat, vld_pat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[6'(wr_ptr)] = b;
    wr_ptr++;
  endtask

  task automatic exp_word(input logic [31:0] d, input logic [2:0] b, input logic l);
    word_t w;
    w.d = d;
    w.b = b;
    w.l = l;
    exp_q.push_back(w);
  endtask

  task automatic get_word(input string nm);
    int    k;
    word_t g;
    word_t e;
    k = 0;
    while (got_rd == got_wr && k < 100) begin
      step();
      k++;
    end
    if (got_rd == got_wr) begin
      chk({nm, "_timeout"}, 64'(got_wr - got_rd), 64'd1);
    end else begin
      g = got[6'(got_rd)];
      got_rd++;
      if (exp_q.size() == 0) begin
        chk({nm, "_unexpected"}, 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk({nm, "_data"},  64'(g.d), 64'(e.d));
        chk({nm, "_bytes"}, 64'(g.b), 64'(e.b));
        chk({nm, "_last"},  64'(g.l), 64'(e.l));
      end
    end
  endtask

  task automatic wait_drained(input string nm);
    int k;
    k = 0;
    while (rd_ptr != wr_ptr && k < 50) begin
      step();
      k++;
    end
    if (rd_ptr != wr_ptr) chk({nm, "_drain"}, 64'(rd_ptr), 64'(wr_ptr));
  endtask

  initial begin
    vecs[0] = '{4, 32'h01800FF0, 1'b0, 32'h01800FF0, 3'd4, 1'b0};
    vecs[1] = '{4, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 3'd4, 1'b0};
    vecs[2] = '{2, 32'h0000BBAA, 1'b1, 32'h0000BBAA, 3'd2, 1'b1};
    vecs[3] = '{1, 32'h000000FF, 1'b1, 32'h000000FF, 3'd1, 1'b1};
    vecs[4] = '{3, 32'h00C0B0A0, 1'b1, 32'h00C0B0A0, 3'd3, 1'b1};
    vecs[5] = '{4, 32'h88776655, 1'b1, 32'h88776655, 3'd4, 1'b0};

    // T1: reset held with a non-empty FIFO
    push(8'h99);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset_c%0d", i),
          64'({fifo_en_rd, out_valid, flush_done, out_last, out_bytes, out_data}), 64'd0);
    end
    step();
    chk("reset_no_read", 64'(rd_ptr), 64'd0);
    wr_ptr = rd_ptr;
    rst    = 1'b0;

    // T2: streaming, four back-to-back reads then one valid cycle
    out_ready = 1'b1;
    step();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    exp_word(32'h44332211, 3'd4, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      en_pat[i]  = fifo_en_rd;
      vld_pat[i] = out_valid;
      step();
    end
    chk("t2_en_rd_pattern", 64'(en_pat), 64'(8'b0000_1111));
    chk("t2_valid_pattern", 64'(vld_pat), 64'(8'b0010_0000));
    get_word("t2");

    // Table-driven words
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < vecs[v].n; k++) push(vecs[v].din[8*k +: 8]);
      exp_word(vecs[v].ed, vecs[v].eb, vecs[v].el);
      if (vecs[v].fl) begin
        wait_drained($sformatf("vec%0d", v));
        step();
        step();
        flush = 1'b1;
        step();
        flush  = 1'b0;
        fd_n   = 0;
        fd_at  = -1;
        acc_at = -100;
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (out_valid && out_ready) acc_at = i;
          if (flush_done) begin
            fd_n++;
            fd_at = i;
          end
          step();
        end
        chk($sformatf("vec%0d_flush_done_count", v), 64'(fd_n), 64'd1);
        if (vecs[v].el) chk($sformatf("vec%0d_flush_done_timing", v), 64'(fd_at), 64'(acc_at + 1));
      end
      get_word($sformatf("vec%0d", v));
      step();
    end

    // T3: backpressure holds the word and blocks reads
    out_ready = 1'b0;
    base = rd_ptr;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    exp_word(32'h44332211, 3'd4, 1'b0);
    exp_word(32'h00000055, 3'd1, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || out_data != 32'h44332211 || out_bytes != 3'd4 || fifo_en_rd) bad++;
      step();
    end
    chk("t3_hold_stable", 64'(bad), 64'd0);
    chk("t3_reads_before_accept", 64'(rd_ptr - base), 64'd4);
    out_ready = 1'b1;
    get_word("t3_full");
    wait_drained("t3");
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    get_word("t3_tail");
    step(); step(); step();

    // T5: flush with nothing buffered
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("t5_idle_flush_done", 64'({flush_done, out_valid}), 64'(2'b10));
    step();
    @(negedge clk);
    chk("t5_idle_flush_done_clear", 64'(flush_done), 64'd0);
    step();

    // T5: flush in the same cycle as a read keeps the in-flight byte
    push(8'hA1); push(8'hB2); push(8'hC3);
    exp_word(32'h00C3B2A1, 3'd3, 1'b1);
    step();
    step();
    flush = 1'b1;
    @(negedge clk);
    chk("t5_read_with_flush", 64'(fifo_en_rd), 64'd1);
    step();
    flush = 1'b0;
    get_word("t5_inflight");
    step(); step(); step();

    // T6: reset in the middle of a word
    push(8'hAA); push(8'hBB); push(8'hCC);
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst    = 1'b0;
    wr_ptr = rd_ptr;
    @(negedge clk);
    chk("t6_after_reset", 64'({out_valid, out_bytes, out_data}), 64'd0);
    step();
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    exp_word(32'h04030201, 3'd4, 1'b0);
    get_word("t6_clean");

    // T6: empty flag toggling every cycle
    push(8'h5A); push(8'h6B); push(8'h7C); push(8'h8D);
    exp_word(32'h8D7C6B5A, 3'd4, 1'b0);
    for (int i = 0; i < 30; i++) begin
      empty_gate = ~empty_gate;
      step();
    end
    empty_gate = 1'b0;
    get_word("t6_toggle");

    for (int i = 0; i < 5; i++) step();
    chk("no_extra_words", 64'(got_wr - got_rd), 64'd0);
    chk("all_expected_seen", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
